serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/ripplecarryadder.sv | 21 ++
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_serial_add_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package serial_add_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/ripplecarryadder.sv
// 4-bit ripple-carry adder, used as the single shared slice adder.
module ripplecarryadder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[4];

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial add/subtract: one 4-bit adder walks the operands LSB slice first,
// taking NIBBLES cycles per operation, with a valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high, last results retained
// RUN   | one slice per cycle through the shared adder
// DONE  | result presented; held until out_ready
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SLICE_W*NIBBLES-1:0]   op_a,
    input  logic [SLICE_W*NIBBLES-1:0]   op_b,
    input  logic                         sub,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SLICE_W*NIBBLES-1:0]   result,
    output logic                         cout,
    output logic                         ovf
);

    localparam int W  = SLICE_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t              state;
    state_t              state_nx;
    logic [IW-1:0]       idx;
    logic                carry;
    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;
    logic [SLICE_W-1:0]  a_sl;
    logic [SLICE_W-1:0]  b_sl;
    logic [SLICE_W-1:0]  sum;
    logic                sum_co;
    logic                accept;
    logic                step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)     state_nx = RUN;
            RUN:     if (idx == LAST)  state_nx = DONE;
            DONE:    if (out_ready)    state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign step      = (state == RUN);

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                a_sl = a_reg[i*SLICE_W +: SLICE_W];
                b_sl = b_reg[i*SLICE_W +: SLICE_W];
            end
        end
    end

    ripplecarryadder u_slice_add (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (sum),
        .cout (sum_co)
    );

    // Subtraction is a + ~b + 1: invert b once at accept and seed the carry with sub.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            idx    <= '0;
            carry  <= sub;
            a_reg  <= op_a;
            b_reg  <= op_b ^ {W{sub}};
            result <= '0;
        end else if (step) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx == IW'(i)) begin
                    result[i*SLICE_W +: SLICE_W] <= sum;
                end
            end
            carry <= sum_co;
            idx   <= idx + IW'(1);
            if (idx == LAST) begin
                // The final slice sum carries the result MSB, so flags settle with it.
                cout <= sum_co;
                ovf  <= (a_reg[W-1] == b_reg[W-1]) && (sum[SLICE_W-1] != a_reg[W-1]);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: arithmetic corners, output hold,
// mid-operation reset and back-to-back throughput.
module tb_serial_add_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op_a = '0;
        op_b = '0;
        sub = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h cout=%b ovf=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, result, cout, ovf);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic transact(input logic [15:0] a, input logic [15:0] b, input logic s,
                            input logic [15:0] er, input logic ec, input logic eo, input string name);
        int cycles;
        op_a = a;
        op_b = b;
        sub = s;
        out_ready = 1'b1;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready: in_ready=%b want 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        op_a = 16'hDEAD;
        op_b = 16'hBEEF;
        sub = ~s;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        checks++;
        if (cycles != 4) begin
            failures++;
            $display("FAIL %s_latency: cycles=%0d want 4", name, cycles);
        end
        checks++;
        if (result !== er || cout !== ec || ovf !== eo) begin
            failures++;
            $display("FAIL %s_value: result=%h cout=%b ovf=%b want %h %b %b", name, result, cout, ovf, er, ec, eo);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_arith();
        transact(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
        transact(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_carry");
        transact(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        transact(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_borrow");
        transact(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    endtask

    task automatic test_reset_midrun();
        int seen;
        op_a = 16'h1111;
        op_b = 16'h2222;
        sub = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b result=%h cout=%b ovf=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, result, cout, ovf);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midrun_no_valid: out_valid cycles=%0d want 0", seen);
        end
        transact(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_hold();
        int cycles;
        int bad;
        op_a = 16'h00FF;
        op_b = 16'h0F01;
        sub = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        checks++;
        if (cycles != 4) begin
            failures++;
            $display("FAIL hold_latency: cycles=%0d want 4", cycles);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            op_a = 16'h1000 + 16'(i);
            op_b = ~op_a;
            sub = i[0];
            in_valid = ~i[0];
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h1000 || cout !== 1'b0 || ovf !== 1'b0) begin
                failures++;
                bad++;
                $display("FAIL hold_stable[%0d]: out_valid=%b in_ready=%b result=%h cout=%b ovf=%b want 1 0 1000 0 0",
                         i, out_valid, in_ready, result, cout, ovf);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (out_valid !== 1'b0 || result !== 16'h1000) begin
            failures++;
            $display("FAIL hold_idle_retain: out_valid=%b result=%h want 0 1000", out_valid, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic        vs [3];
        logic [15:0] er [3];
        logic        ec [3];
        int k;
        int nacc;
        int nout;
        int last;
        int cyc;
        logic pend;
        va = '{16'h0001, 16'h1000, 16'hABCD};
        vb = '{16'h0002, 16'h0001, 16'h1111};
        vs = '{1'b0, 1'b1, 1'b0};
        er = '{16'h0003, 16'h0FFF, 16'hBCDE};
        ec = '{1'b0, 1'b1, 1'b0};
        k = 0;
        nacc = 0;
        nout = 0;
        last = 0;
        out_ready = 1'b1;
        op_a = va[0];
        op_b = vb[0];
        sub = vs[0];
        in_valid = 1'b1;
        for (cyc = 0; cyc < 40; cyc++) begin
            pend = 1'b0;
            if (out_valid) begin
                checks++;
                if (nout > 2) begin
                    failures++;
                    $display("FAIL b2b_extra_out: out %0d result=%h want none", nout, result);
                end else if (result !== er[nout] || cout !== ec[nout] || ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_result[%0d]: result=%h cout=%b ovf=%b want %h %b 0",
                             nout, result, cout, ovf, er[nout], ec[nout]);
                end
                nout++;
            end
            if (in_ready && in_valid) begin
                if (nacc > 0) begin
                    checks++;
                    if (cyc - last != 6) begin
                        failures++;
                        $display("FAIL b2b_spacing[%0d]: gap=%0d want 6", nacc, cyc - last);
                    end
                end
                last = cyc;
                nacc++;
                pend = 1'b1;
            end
            tick();
            if (pend) begin
                k++;
                if (k < 3) begin
                    op_a = va[k];
                    op_b = vb[k];
                    sub = vs[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nacc != 3 || nout != 3) begin
            failures++;
            $display("FAIL b2b_count: accepts=%0d outputs=%0d want 3 3", nacc, nout);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_reset_midrun();
        test_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
